// File: rtl/recovery_lockin_controller_if.sv
// ---------------------------------------------------------------------------
// recovery_lockin_controller_if
// Bundles the edge/rate measurement inputs, qualification configuration and
// lock-tracking outputs of recovery_lockin_controller.
//   slave  : controller side (measurement/config in, lock status out)
//   master : upstream/driver side (measurement/config out, lock status in)
// Parameter W is the rate/bound/window width (RATE_COUNTER_WIDTH).
// ---------------------------------------------------------------------------
interface recovery_lockin_controller_if #(
  parameter int W = 16
);
  logic         rising_edge_i;
  logic         falling_edge_i;
  logic         event_polarity_en_i;
  logic         event_polarity_i;
  logic [W-1:0] pending_rate_i;
  logic [W-1:0] bandpass_upper_bound_i;
  logic [W-1:0] bandpass_lower_bound_i;
  logic         drift_polarity_en_i;
  logic         drift_polarity_i;
  logic [W-1:0] drift_window_i;
  logic         clock_encoded_data_en_i;
  logic         lock_clear_i;

  logic         primary_event_o;
  logic         rate_locked_o;
  logic [1:0]   lock_state_o;
  logic [W-1:0] validated_rate_o;
  logic         bandpass_overshoot_o;
  logic         bandpass_undershoot_o;
  logic         positive_drift_violation_o;
  logic         negative_drift_violation_o;
  logic         halving_event_o;
  logic         lock_lost_o;

  modport slave (
    input  rising_edge_i, falling_edge_i, event_polarity_en_i, event_polarity_i,
           pending_rate_i, bandpass_upper_bound_i, bandpass_lower_bound_i,
           drift_polarity_en_i, drift_polarity_i, drift_window_i,
           clock_encoded_data_en_i, lock_clear_i,
    output primary_event_o, rate_locked_o, lock_state_o, validated_rate_o,
           bandpass_overshoot_o, bandpass_undershoot_o,
           positive_drift_violation_o, negative_drift_violation_o,
           halving_event_o, lock_lost_o
  );

  modport master (
    output rising_edge_i, falling_edge_i, event_polarity_en_i, event_polarity_i,
           pending_rate_i, bandpass_upper_bound_i, bandpass_lower_bound_i,
           drift_polarity_en_i, drift_polarity_i, drift_window_i,
           clock_encoded_data_en_i, lock_clear_i,
    input  primary_event_o, rate_locked_o, lock_state_o, validated_rate_o,
           bandpass_overshoot_o, bandpass_undershoot_o,
           positive_drift_violation_o, negative_drift_violation_o,
           halving_event_o, lock_lost_o
  );
endinterface

// File: rtl/recovery_lockin_controller.sv
// ---------------------------------------------------------------------------
// recovery_lockin_controller
// Qualifies recovered edge events (polarity + bandpass), acquires lock after
// LOCK_COUNT consecutive consistent rates, then tracks the rate with a
// shift-based IIR. While locked it flags drift, accepts half-rate events for
// clock-encoded data and drops lock after LOSS_COUNT consecutive violations.
// Ports:
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset
//   bus     : recovery_lockin_controller_if.slave (events, config, status)
// All outputs are registered; responses appear the cycle after the event.
// ---------------------------------------------------------------------------
module recovery_lockin_controller #(
  parameter int RATE_COUNTER_WIDTH = 16,
  parameter int LOCK_COUNT         = 4,
  parameter int LOSS_COUNT         = 3,
  parameter int FILTER_SHIFT       = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  recovery_lockin_controller_if.slave   bus
);
  localparam int W  = RATE_COUNTER_WIDTH;
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int VW = $clog2(LOSS_COUNT + 1);

  localparam logic [MW-1:0] LOCK_CNT_C  = MW'(LOCK_COUNT);
  localparam logic [MW-1:0] MATCH_ONE_C = MW'(1);
  localparam logic [VW-1:0] LOSS_CNT_C  = VW'(LOSS_COUNT);
  localparam bit            LOCK_NOW_C  = (LOCK_COUNT == 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_ACQUIRING = 2'd1,
    ST_LOCKED    = 2'd2
  } state_e;

  // Returns {hi, lo}: reference +/- window, saturated to [0, 2^W-1];
  // one-directional drift pins the disallowed side to the reference.
  function automatic logic [2*W-1:0] window_bounds(
    input logic [W-1:0] ref_rate,
    input logic [W-1:0] win,
    input logic         pol_en,
    input logic         pol
  );
    logic [W:0]   hi_ext;
    logic [W:0]   lo_ext;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    hi_ext = {1'b0, ref_rate} + {1'b0, win};
    lo_ext = {1'b0, ref_rate} - {1'b0, win};
    // bit W of lo_ext is the borrow: window larger than reference
    hi = hi_ext[W] ? {W{1'b1}} : hi_ext[W-1:0];
    lo = lo_ext[W] ? {W{1'b0}} : lo_ext[W-1:0];
    hi = (pol_en && !pol) ? ref_rate : hi;
    lo = (pol_en &&  pol) ? ref_rate : lo;
    return {hi, lo};
  endfunction

  // One IIR step: r + floor((p - r) / 2^FILTER_SHIFT), saturated to W bits.
  function automatic logic [W-1:0] iir_step(
    input logic [W-1:0] r,
    input logic [W-1:0] p
  );
    logic signed [W:0]   diff;
    logic signed [W:0]   step;
    logic signed [W+1:0] sum;
    logic [W-1:0]        res;
    diff = $signed({1'b0, p}) - $signed({1'b0, r});
    step = diff >>> FILTER_SHIFT;
    sum  = $signed({2'b00, r}) + $signed({step[W], step});
    if (sum[W+1]) begin
      res = {W{1'b0}};
    end else if (sum[W]) begin
      res = {W{1'b1}};
    end else begin
      res = sum[W-1:0];
    end
    return res;
  endfunction

  state_e        state_q, state_d;
  logic [W-1:0]  validated_q, validated_d;
  logic [MW-1:0] match_q, match_d;
  logic [VW-1:0] viol_q, viol_d;
  logic          primary_q, primary_d;
  logic          locked_q, locked_d;
  logic          over_q, over_d;
  logic          under_q, under_d;
  logic          pos_q, pos_d;
  logic          neg_q, neg_d;
  logic          halve_q, halve_d;
  logic          lost_q, lost_d;

  logic          ev_s, over_s, under_s, acc_s;
  logic [W-1:0]  hi_s, lo_s, half_hi_s, half_lo_s;
  logic          in_win_s, half_win_s;
  logic [MW-1:0] match_inc_s;
  logic [VW-1:0] viol_inc_s;

  // Event qualification, windows and saturating counter increments.
  always_comb begin
    if (bus.event_polarity_en_i) begin
      ev_s = bus.event_polarity_i ? bus.rising_edge_i : bus.falling_edge_i;
    end else begin
      ev_s = bus.rising_edge_i | bus.falling_edge_i;
    end
    over_s  = bus.pending_rate_i > bus.bandpass_upper_bound_i;
    under_s = bus.pending_rate_i < bus.bandpass_lower_bound_i;
    acc_s   = ev_s && !over_s && !under_s;

    {hi_s, lo_s} = window_bounds(validated_q, bus.drift_window_i,
                                 bus.drift_polarity_en_i, bus.drift_polarity_i);
    {half_hi_s, half_lo_s} = window_bounds(validated_q >> 1, bus.drift_window_i,
                                           bus.drift_polarity_en_i, bus.drift_polarity_i);
    in_win_s   = (bus.pending_rate_i >= lo_s) && (bus.pending_rate_i <= hi_s);
    half_win_s = bus.clock_encoded_data_en_i &&
                 (bus.pending_rate_i >= half_lo_s) && (bus.pending_rate_i <= half_hi_s);

    match_inc_s = (match_q < LOCK_CNT_C) ? match_q + MATCH_ONE_C : match_q;
    viol_inc_s  = (viol_q < LOSS_CNT_C) ? viol_q + VW'(1) : viol_q;
  end

  // Lock FSM next state, rate tracking and output pulses.
  always_comb begin
    state_d     = state_q;
    validated_d = validated_q;
    match_d     = match_q;
    viol_d      = viol_q;
    primary_d   = acc_s;
    over_d      = ev_s && over_s;
    under_d     = ev_s && under_s;
    pos_d       = 1'b0;
    neg_d       = 1'b0;
    halve_d     = 1'b0;
    lost_d      = 1'b0;

    if (bus.lock_clear_i) begin
      // Forced unlock wins over any same-cycle event; nothing is captured.
      state_d = ST_UNLOCKED;
      match_d = {MW{1'b0}};
      viol_d  = {VW{1'b0}};
    end else if (ev_s) begin
      case (state_q)
        ST_UNLOCKED: begin
          if (acc_s) begin
            validated_d = bus.pending_rate_i;
            match_d     = MATCH_ONE_C;
            viol_d      = {VW{1'b0}};
            state_d     = LOCK_NOW_C ? ST_LOCKED : ST_ACQUIRING;
          end else begin
            state_d = ST_UNLOCKED;
          end
        end
        ST_ACQUIRING: begin
          if (acc_s && in_win_s) begin
            match_d = match_inc_s;
            if (match_inc_s == LOCK_CNT_C) begin
              state_d = ST_LOCKED;
              viol_d  = {VW{1'b0}};
            end else begin
              state_d = ST_ACQUIRING;
            end
          end else if (acc_s) begin
            // Inconsistent rate: restart acquisition around the new rate.
            validated_d = bus.pending_rate_i;
            match_d     = MATCH_ONE_C;
          end else begin
            state_d = ST_ACQUIRING;
          end
        end
        ST_LOCKED: begin
          if (acc_s && in_win_s) begin
            viol_d      = {VW{1'b0}};
            validated_d = iir_step(validated_q, bus.pending_rate_i);
          end else if (acc_s && half_win_s) begin
            halve_d = 1'b1;
          end else begin
            viol_d = viol_inc_s;
            pos_d  = bus.pending_rate_i > hi_s;
            neg_d  = bus.pending_rate_i < lo_s;
            if (viol_inc_s == LOSS_CNT_C) begin
              state_d = ST_UNLOCKED;
              lost_d  = 1'b1;
              match_d = {MW{1'b0}};
              viol_d  = {VW{1'b0}};
            end else begin
              state_d = ST_LOCKED;
            end
          end
        end
        default: begin
          state_d = ST_UNLOCKED;
          match_d = {MW{1'b0}};
          viol_d  = {VW{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State, tracked rate, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_UNLOCKED;
      validated_q <= {W{1'b0}};
      match_q     <= {MW{1'b0}};
      viol_q      <= {VW{1'b0}};
      primary_q   <= 1'b0;
      locked_q    <= 1'b0;
      over_q      <= 1'b0;
      under_q     <= 1'b0;
      pos_q       <= 1'b0;
      neg_q       <= 1'b0;
      halve_q     <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      validated_q <= validated_d;
      match_q     <= match_d;
      viol_q      <= viol_d;
      primary_q   <= primary_d;
      locked_q    <= locked_d;
      over_q      <= over_d;
      under_q     <= under_d;
      pos_q       <= pos_d;
      neg_q       <= neg_d;
      halve_q     <= halve_d;
      lost_q      <= lost_d;
    end
  end

  assign bus.primary_event_o            = primary_q;
  assign bus.rate_locked_o              = locked_q;
  assign bus.lock_state_o               = state_q;
  assign bus.validated_rate_o           = validated_q;
  assign bus.bandpass_overshoot_o       = over_q;
  assign bus.bandpass_undershoot_o      = under_q;
  assign bus.positive_drift_violation_o = pos_q;
  assign bus.negative_drift_violation_o = neg_q;
  assign bus.halving_event_o            = halve_q;
  assign bus.lock_lost_o                = lost_q;

endmodule

// File: doc/recovery_lockin_controller.md
Name: recovery_lockin_controller

Overview:
Parametrised, stateful successor to the combinational recovery filter stage in the clock-recovery path. It qualifies recovered edge events by polarity and bandpass, acquires lock after LOCK_COUNT consecutive consistent rate measurements, and then tracks the validated rate with a shift-based IIR filter. While locked it flags drift violations, recognises half-rate events for clock-encoded data, and drops lock after LOSS_COUNT consecutive violations. It sits between the edge/rate measurement stage and the recovered-clock generator, and drives primary_event_o and rate_locked_o downstream.

Parameters:
RATE_COUNTER_WIDTH, 16, width of all rate/bound/window quantities (W)
LOCK_COUNT, 4, consecutive in-window events required to lock (>=1)
LOSS_COUNT, 3, consecutive violations that drop lock (>=1)
FILTER_SHIFT, 2, IIR gain shift; 0 = validated rate replaced by pending rate

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
rising_edge_i  in  1  recovered rising edge; pending_rate_i valid this cycle
falling_edge_i  in  1  recovered falling edge; pending_rate_i valid this cycle
event_polarity_en_i  in  1  1 = single-edge mode
event_polarity_i  in  1  1 = rising only, 0 = falling only (when enabled)
pending_rate_i  in  W  measured rate for current event
bandpass_upper_bound_i  in  W  max legal rate
bandpass_lower_bound_i  in  W  min legal rate
drift_polarity_en_i  in  1  1 = one-directional drift only
drift_polarity_i  in  1  1 = positive only, 0 = negative only
drift_window_i  in  W  allowed deviation
clock_encoded_data_en_i  in  1  enable half-rate acceptance
lock_clear_i  in  1  synchronous forced unlock
primary_event_o  out  1  registered qualified event
rate_locked_o  out  1  state==LOCKED
lock_state_o  out  2  0 UNLOCKED, 1 ACQUIRING, 2 LOCKED
validated_rate_o  out  W  current locked/candidate rate
bandpass_overshoot_o  out  1  pulse: event with pending > upper bound
bandpass_undershoot_o  out  1  pulse: event with pending < lower bound
positive_drift_violation_o  out  1  pulse, LOCKED only
negative_drift_violation_o  out  1  pulse, LOCKED only
halving_event_o  out  1  pulse: half-rate event accepted
lock_lost_o  out  1  pulse: LOCKED -> UNLOCKED due to violations

Behaviour:
- Reset: all outputs 0, state UNLOCKED, match/violation counters 0, validated_rate 0.
- All outputs registered; response appears the cycle after the event.
- ev = polarity-filtered event: any edge if polarity_en=0, else rising (pol=1) or falling (pol=0). No event -> only pulses clear; state holds.
- bp_fail = pending > upper or pending < lower; pulses fire on ev in any state.
- acc = ev && !bp_fail; primary_event_o <= acc.
- Window around reference R (validated_rate): hi = R+window, lo = R-window, computed in W+1 bits and saturated to [0, 2^W-1]; drift_polarity_en && !pol -> hi = R; drift_polarity_en && pol -> lo = R. in_win = lo <= pending <= hi.
- Halving window uses R>>1 as reference, same rules; half_win is valid only if clock_encoded_data_en_i=1.
- UNLOCKED: acc -> validated = pending, match = 1; if LOCK_COUNT==1 go LOCKED, else ACQUIRING.
- ACQUIRING: acc && in_win -> match+1, validated unchanged; when match reaches LOCK_COUNT -> LOCKED, violation = 0. acc && !in_win -> validated = pending, match = 1 (restart).
- LOCKED: acc && in_win -> violation = 0; validated += signed(pending-R) >>> FILTER_SHIFT (arithmetic, W+1-bit signed, floors toward -inf, result saturated).
- LOCKED: acc && !in_win && half_win -> halving_event_o pulse, no update, violation unchanged.
- LOCKED: otherwise (ev && bp_fail, or acc outside both windows) -> violation+1; drift pulse by side (pending > hi positive, pending < lo negative; neither if only bp_fail within window). At violation == LOSS_COUNT -> UNLOCKED, lock_lost_o pulse, counters cleared; validated_rate_o holds last value.
- lock_clear_i: -> UNLOCKED and counters 0 next cycle, priority over any same-cycle event (no capture); primary_event_o and bandpass pulses still reflect that event; no lock_lost_o.
- Counters saturate; they never wrap.

Test Plan:
- Reset asserted mid-ACQUIRING -> all outputs 0 immediately (async), state UNLOCKED after release.
- W=16, LOCK_COUNT=4, window=2, bp 50..200, rising edges with rates 100,101,99,100 -> rate_locked_o=1 and validated=100 the cycle after the 4th event; primary_event_o pulses on each event.
- Same config, rates 100,100,110 -> lock_state stays 1, validated=110, match restarts; a following 250 -> bandpass_overshoot_o pulse with no state change.
- Locked at 100, window=8, FILTER_SHIFT=2, pending 108 -> validated 102; then pending 99 -> 102+floor(-3/4)=101.
- Locked at 100, window=2, clock_encoded=1: pending 51 -> halving_event_o, no violation; three events at 70 -> negative_drift_violation_o pulses x3, then lock_lost_o pulse and state UNLOCKED.
- Saturation and priority: validated=1, window=5, pending 0 -> no violation (lo saturates to 0); lock_clear_i in the same cycle as an acc event -> UNLOCKED, validated unchanged, primary_event_o=1.
